// File: rtl/wb_data_ram_slave_if.sv
// rtl/wb_data_ram_slave_if.sv - Wishbone classic bus bundle for the data RAM slave
interface wb_data_ram_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_data_ram_slave.sv
// rtl/wb_data_ram_slave.sv - Wishbone 32-bit data RAM slave with programmable wait states
// Optional address error termination enabled by defining WB_RAM_ADDR_ERR_EN.
module wb_data_ram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  wb_data_ram_slave_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [0:DEPTH-1];
  state_t            state;
  logic [3:0]        cnt;
  logic [1:0]        rst_sync;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_idx;
  logic [3:0]        lat_sel;
  logic [31:0]       lat_dat;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       dat_q;

  logic              ready;
  logic              req;
  logic              addr_err;
  logic              enter_resp;
  logic              cur_we;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [3:0]        cur_sel;
  logic [31:0]       cur_dat;

  // Requests are held off until reset release has passed through both sync flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign ready = rst_sync[1];
  assign req   = ready && bus.wb_cyc_i && bus.wb_stb_i;

`ifdef WB_RAM_ADDR_ERR_EN
  assign addr_err = (|bus.wb_adr_i[31:ADDR_W+2]) || (|bus.wb_adr_i[1:0]);
`else
  assign addr_err = 1'b0;
  wire unused_adr = ^{bus.wb_adr_i[31:ADDR_W+2], bus.wb_adr_i[1:0]};
`endif

  // With zero wait states the commit happens on the same edge that latches the request.
  always_comb begin
    cur_we  = lat_we;
    cur_err = lat_err;
    cur_idx = lat_idx;
    cur_sel = lat_sel;
    cur_dat = lat_dat;
    if (state == ST_IDLE) begin
      cur_we  = bus.wb_we_i;
      cur_err = addr_err;
      cur_idx = bus.wb_adr_i[ADDR_W+1:2];
      cur_sel = bus.wb_sel_i;
      cur_dat = bus.wb_dat_i;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == ST_IDLE && req && WAIT_CYCLES == 0)
      enter_resp = 1'b1;
    else if (state == ST_WAIT && bus.wb_cyc_i && cnt == 4'd0)
      enter_resp = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      lat_we  <= 1'b0;
      lat_err <= 1'b0;
      lat_idx <= '0;
      lat_sel <= 4'd0;
      lat_dat <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_we  <= bus.wb_we_i;
            lat_err <= addr_err;
            lat_idx <= bus.wb_adr_i[ADDR_W+1:2];
            lat_sel <= bus.wb_sel_i;
            lat_dat <= bus.wb_dat_i;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.wb_cyc_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        ack_q <= !cur_err;
        err_q <= cur_err;
        if (!cur_we && !cur_err) dat_q <= mem[cur_idx];
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// tb/tb_wb_data_ram_slave.sv - self-checking bench for wb_data_ram_slave (3 and 0 wait states)
module tb_wb_data_ram_slave;
  localparam int AW = 10;
  localparam int WA = 3;
  localparam int WB = 0;
`ifdef WB_RAM_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tgt, cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  wb_data_ram_slave_if bus_a ();
  wb_data_ram_slave_if bus_b ();

  assign bus_a.wb_cyc_i = cyc & ~tgt;
  assign bus_a.wb_stb_i = stb & ~tgt;
  assign bus_a.wb_we_i  = we;
  assign bus_a.wb_adr_i = adr;
  assign bus_a.wb_sel_i = sel;
  assign bus_a.wb_dat_i = dat;
  assign bus_b.wb_cyc_i = cyc & tgt;
  assign bus_b.wb_stb_i = stb & tgt;
  assign bus_b.wb_we_i  = we;
  assign bus_b.wb_adr_i = adr;
  assign bus_b.wb_sel_i = sel;
  assign bus_b.wb_dat_i = dat;

  wb_data_ram_slave #(.ADDR_W(AW), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  wb_data_ram_slave #(.ADDR_W(AW), .WAIT_CYCLES(WB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  wire        ack  = tgt ? bus_b.wb_ack_o : bus_a.wb_ack_o;
  wire        err  = tgt ? bus_b.wb_err_o : bus_a.wb_err_o;
  wire [31:0] rdat = tgt ? bus_b.wb_dat_o : bus_a.wb_dat_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_dat [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    return ERR_EN && (((a >> (AW + 2)) != 0) || (a[1:0] != 2'b00));
  endfunction

  task automatic access(input bit t, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input string tag);
    int          lat;
    int          wc;
    int          idx;
    bit          e;
    logic        got_ack, got_err;
    logic [31:0] got_dat;
    wc = t ? WB : WA;
    e = exp_err(a);
    idx = int'((a >> 2) % 1024);
    @(posedge clk); #1;
    tgt = t; we = w; adr = a; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'hx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = k; got_ack = ack; got_err = err; got_dat = rdat;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    if (!e) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[t][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        last_dat[t] = ref_mem[t][idx];
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(wc + 1));
    check({tag, "_ack"}, 32'(got_ack), 32'(!e));
    check({tag, "_err"}, 32'(got_err), 32'(e));
    check({tag, "_dat"}, got_dat, last_dat[t]);
    @(negedge clk);
    check({tag, "_pulse"}, 32'({ack, err}), 32'd0);
  endtask

  initial begin
    bit          saw;
    logic [31:0] a;
    int          idx;
    tgt = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; sel = 4'd0; dat = 32'd0;
    last_dat[0] = 32'd0; last_dat[1] = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_a", {bus_a.wb_dat_o[29:0], bus_a.wb_ack_o, bus_a.wb_err_o}, 32'd0);
    check("rst_a_dat", bus_a.wb_dat_o, 32'd0);
    check("rst_b_dat", bus_b.wb_dat_o, 32'd0);
    check("rst_b_ae", 32'({bus_b.wb_ack_o, bus_b.wb_err_o}), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++)
        access(t[0], 1'b1, 32'(i * 4), 4'hF, $urandom, "init");

    access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr_full");
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "rd_full");
    check("rd_deadbeef", bus_a.wb_dat_o, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h10, 4'h1, 32'h000000AA, "wr_byte");
    access(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, "rd_byte");
    check("rd_deadbeaa", bus_a.wb_dat_o, 32'hDEADBEAA);
    access(1'b0, 1'b1, 32'h10, 4'h0, 32'h55555555, "wr_nosel");
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "rd_nosel");

    // Abort: cyc dropped during the second wait cycle of the 3-wait-state slave.
    @(posedge clk); #1;
    tgt = 1'b0; we = 1'b1; adr = 32'h10; sel = 4'hF; dat = 32'h0BAD0BAD; cyc = 1'b1; stb = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      saw |= (ack | err);
      if (k == 1) begin
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
      end
    end
    check("abort_no_resp", 32'(saw), 32'd0);
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "after_abort");

    // Continuous request on the zero-wait slave: ack every other cycle.
    @(posedge clk); #1;
    tgt = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b2b_ack", 32'(ack), 32'(k % 2));
      if (ack) check("b2b_dat", rdat, ref_mem[1][2]);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    last_dat[1] = ref_mem[1][2];

    access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h12345678, "hi_wr");
    access(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, "w0_rd");
    access(1'b0, 1'b0, 32'h1000, 4'hF, 32'h0, "hi_rd");
    access(1'b1, 1'b0, 32'h0000_2006, 4'hF, 32'h0, "mis_rd");

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      a = 32'(idx * 4);
      if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 15)) << 12;
      if ($urandom_range(0, 5) == 0) a |= 32'($urandom_range(1, 3));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
             $urandom, "rand");
    end

    // Reset during WAIT cancels the pending write and clears outputs at once.
    access(1'b0, 1'b0, 32'hC, 4'hF, 32'h0, "pre_rst");
    @(posedge clk); #1;
    tgt = 1'b0; we = 1'b1; adr = 32'h0; sel = 4'hF; dat = ~ref_mem[0][0]; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_ack", 32'(bus_a.wb_ack_o), 32'd0);
    check("midrst_err", 32'(bus_a.wb_err_o), 32'd0);
    check("midrst_dat", bus_a.wb_dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    last_dat[0] = 32'd0; last_dat[1] = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    access(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, "rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
